// File: rtl/pc_write_ctrl_if.sv
// Fetch-control bundle between the pipeline (master) and pc_write_ctrl (slave).
// Carries PC, redirect, hazard and memory-ready inputs plus PC/IF-ID controls.
interface pc_write_ctrl_if;
   logic [31:0] pc_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        load_use_i;
   logic        imem_ready_i;
   logic [31:0] pc_next_o;
   logic        PCWrite_o;
   logic        IFID_write_o;
   logic        IF_flush_o;
   logic        ID_bubble_o;

   modport master (
      output pc_i, redirect_i, redirect_pc_i, load_use_i, imem_ready_i,
      input  pc_next_o, PCWrite_o, IFID_write_o, IF_flush_o, ID_bubble_o
   );

   modport slave (
      input  pc_i, redirect_i, redirect_pc_i, load_use_i, imem_ready_i,
      output pc_next_o, PCWrite_o, IFID_write_o, IF_flush_o, ID_bubble_o
   );
endinterface

// File: rtl/pc_write_ctrl.sv
// PC update / IF-ID control with redirect, load-use stall and imem wait handling.
// Optional performance counters enabled by macro PC_WRITE_CTRL_PERF_CNT_EN.
module pc_write_ctrl (
   input  logic               clk_i,
   input  logic               rst_i,
   pc_write_ctrl_if.slave     bus,
   output logic [31:0]        stall_cnt_o,
   output logic [31:0]        flush_cnt_o
);
   typedef enum logic [1:0] {RUN, HAZ, MEMW} state_t;

   state_t      state_reg, state_next;
   logic        pend_vld_reg, pend_vld_next;
   logic [31:0] pend_pc_reg, pend_pc_next;
   logic [31:0] pc_seq;
   logic [31:0] pc_next;
   logic        pc_write, ifid_write, if_flush, id_bubble;

   assign pc_seq = bus.pc_i + 32'd4;

   // Priority: redirect, then a pending redirect waiting on imem, then load-use, then imem wait.
   always_comb begin
      state_next    = state_reg;
      pend_vld_next = pend_vld_reg;
      pend_pc_next  = pend_pc_reg;
      pc_next       = pc_seq;
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      if_flush      = 1'b0;
      id_bubble     = 1'b0;
      if (!rst_i) begin
         state_next    = RUN;
         pend_vld_next = 1'b0;
         pend_pc_next  = 32'd0;
         pc_next       = 32'd0;
         pc_write      = 1'b0;
         ifid_write    = 1'b0;
         if_flush      = 1'b1;
      end else if (bus.redirect_i) begin
         if_flush = 1'b1;
         if (bus.imem_ready_i) begin
            pc_next       = bus.redirect_pc_i;
            pend_vld_next = 1'b0;
            state_next    = RUN;
         end else begin
            // Latest redirect wins while fetch is blocked.
            pc_next       = bus.pc_i;
            pc_write      = 1'b0;
            pend_pc_next  = bus.redirect_pc_i;
            pend_vld_next = 1'b1;
            state_next    = MEMW;
         end
      end else if (state_reg == MEMW && pend_vld_reg) begin
         if_flush = 1'b1;
         if (bus.imem_ready_i) begin
            pc_next       = pend_pc_reg;
            pend_vld_next = 1'b0;
            state_next    = RUN;
         end else begin
            pc_next  = bus.pc_i;
            pc_write = 1'b0;
         end
      end else if (bus.load_use_i && state_reg != HAZ) begin
         pc_next    = bus.pc_i;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         id_bubble  = 1'b1;
         state_next = HAZ;
      end else if (!bus.imem_ready_i) begin
         pc_next    = bus.pc_i;
         pc_write   = 1'b0;
         if_flush   = 1'b1;
         state_next = MEMW;
      end else begin
         state_next = RUN;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg    <= RUN;
         pend_vld_reg <= 1'b0;
         pend_pc_reg  <= 32'd0;
      end else begin
         state_reg    <= state_next;
         pend_vld_reg <= pend_vld_next;
         pend_pc_reg  <= pend_pc_next;
      end
   end

   assign bus.pc_next_o    = pc_next;
   assign bus.PCWrite_o    = pc_write;
   assign bus.IFID_write_o = ifid_write;
   assign bus.IF_flush_o   = if_flush;
   assign bus.ID_bubble_o  = id_bubble;

`ifdef PC_WRITE_CTRL_PERF_CNT_EN
   logic [31:0] stall_cnt_reg, flush_cnt_reg;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_reg <= 32'd0;
         flush_cnt_reg <= 32'd0;
      end else begin
         if (!pc_write) stall_cnt_reg <= stall_cnt_reg + 32'd1;
         if (if_flush)  flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_reg;
   assign flush_cnt_o = flush_cnt_reg;
`else
   assign stall_cnt_o = 32'd0;
   assign flush_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_pc_write_ctrl.sv
// Directed bench for pc_write_ctrl: reset, sequential, load-use, redirect,
// imem wait with pending redirect, wrap-around and reset during a wait.
module tb_pc_write_ctrl;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [31:0] stall_cnt_o, flush_cnt_o;
   int          n_cmp = 0;
   int          n_err = 0;

   pc_write_ctrl_if bus ();

   pc_write_ctrl dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .bus         (bus.slave),
      .stall_cnt_o (stall_cnt_o),
      .flush_cnt_o (flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic drive(input logic [31:0] pc, input logic redir, input logic [31:0] rpc,
                        input logic lu, input logic rdy);
      bus.pc_i          = pc;
      bus.redirect_i    = redir;
      bus.redirect_pc_i = rpc;
      bus.load_use_i    = lu;
      bus.imem_ready_i  = rdy;
   endtask

   task automatic show(input string tag);
      $display("%s: pc=%h next=%h pcw=%0b ifid=%0b flush=%0b bubble=%0b stall=%0d flushes=%0d",
               tag, bus.pc_i, bus.pc_next_o, bus.PCWrite_o, bus.IFID_write_o,
               bus.IF_flush_o, bus.ID_bubble_o, stall_cnt_o, flush_cnt_o);
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk_i);
      show("reset");
      n_cmp++; if (bus.pc_next_o !== 32'h0) begin n_err++; $display("FAIL rst_pc_next: got %h exp 00000000", bus.pc_next_o); end
      n_cmp++; if (bus.PCWrite_o !== 1'b0) begin n_err++; $display("FAIL rst_pcwrite: got %b exp 0", bus.PCWrite_o); end
      n_cmp++; if (bus.IFID_write_o !== 1'b0) begin n_err++; $display("FAIL rst_ifid: got %b exp 0", bus.IFID_write_o); end
      n_cmp++; if (bus.IF_flush_o !== 1'b1) begin n_err++; $display("FAIL rst_flush: got %b exp 1", bus.IF_flush_o); end
      n_cmp++; if (bus.ID_bubble_o !== 1'b0) begin n_err++; $display("FAIL rst_bubble: got %b exp 0", bus.ID_bubble_o); end
      n_cmp++; if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d exp 0/0", stall_cnt_o, flush_cnt_o); end
   endtask

   task automatic test_sequential();
      logic [31:0] pc;
      pc = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         rst_i = 1'b1;
         drive(pc, 1'b0, 32'h0, 1'b0, 1'b1);
         @(negedge clk_i);
         show("seq");
         n_cmp++; if (bus.pc_next_o !== pc + 32'd4) begin n_err++; $display("FAIL seq_pc%0d: got %h exp %h", i, bus.pc_next_o, pc + 32'd4); end
         n_cmp++; if (bus.PCWrite_o !== 1'b1 || bus.IF_flush_o !== 1'b0) begin n_err++; $display("FAIL seq_ctl%0d: got pcw=%b flush=%b exp 1/0", i, bus.PCWrite_o, bus.IF_flush_o); end
         pc = pc + 32'd4;
      end
   endtask

   task automatic test_load_use();
      @(posedge clk_i); #1;
      drive(32'h20, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk_i);
      show("lu1");
      n_cmp++; if (bus.PCWrite_o !== 1'b0 || bus.ID_bubble_o !== 1'b1 || bus.IFID_write_o !== 1'b0) begin
         n_err++; $display("FAIL lu_stall: got pcw=%b bub=%b ifid=%b exp 0/1/0", bus.PCWrite_o, bus.ID_bubble_o, bus.IFID_write_o); end
      @(posedge clk_i); #1;
      drive(32'h20, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk_i);
      show("lu2");
      n_cmp++; if (bus.pc_next_o !== 32'h24) begin n_err++; $display("FAIL lu_resume_pc: got %h exp 00000024", bus.pc_next_o); end
      n_cmp++; if (bus.PCWrite_o !== 1'b1 || bus.ID_bubble_o !== 1'b0) begin n_err++; $display("FAIL lu_resume_ctl: got pcw=%b bub=%b exp 1/0", bus.PCWrite_o, bus.ID_bubble_o); end
   endtask

   task automatic test_redirect();
      @(posedge clk_i); #1;
      drive(32'h40, 1'b1, 32'h100, 1'b1, 1'b1);
      @(negedge clk_i);
      show("redir");
      n_cmp++; if (bus.pc_next_o !== 32'h100) begin n_err++; $display("FAIL redir_pc: got %h exp 00000100", bus.pc_next_o); end
      n_cmp++; if (bus.PCWrite_o !== 1'b1 || bus.IF_flush_o !== 1'b1 || bus.ID_bubble_o !== 1'b0) begin
         n_err++; $display("FAIL redir_ctl: got pcw=%b flush=%b bub=%b exp 1/1/0", bus.PCWrite_o, bus.IF_flush_o, bus.ID_bubble_o); end
   endtask

   task automatic test_memwait();
      logic [31:0] rpc [4];
      logic        rdir [4];
      logic [31:0] exp_stall, exp_flush;
      rpc[0] = 32'h200; rpc[1] = 32'h300; rpc[2] = 32'h0; rpc[3] = 32'h0;
      rdir[0] = 1'b1;   rdir[1] = 1'b1;   rdir[2] = 1'b0; rdir[3] = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i); #1;
         rst_i = 1'b1;
         drive(32'h80, rdir[i], rpc[i], 1'b0, (i == 3));
         @(negedge clk_i);
         show("memw");
         if (i < 3) begin
            n_cmp++; if (bus.PCWrite_o !== 1'b0 || bus.IF_flush_o !== 1'b1) begin
               n_err++; $display("FAIL memw_wait%0d: got pcw=%b flush=%b exp 0/1", i, bus.PCWrite_o, bus.IF_flush_o); end
         end else begin
            n_cmp++; if (bus.pc_next_o !== 32'h300 || bus.PCWrite_o !== 1'b1) begin
               n_err++; $display("FAIL memw_release: got pc=%h pcw=%b exp 00000300/1", bus.pc_next_o, bus.PCWrite_o); end
         end
      end
      @(posedge clk_i); #1;
      drive(32'h300, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk_i);
      show("memw_after");
      n_cmp++; if (bus.pc_next_o !== 32'h304 || bus.IF_flush_o !== 1'b0) begin
         n_err++; $display("FAIL memw_after: got pc=%h flush=%b exp 00000304/0", bus.pc_next_o, bus.IF_flush_o); end
`ifdef PC_WRITE_CTRL_PERF_CNT_EN
      exp_stall = 32'd3; exp_flush = 32'd4;
`else
      exp_stall = 32'd0; exp_flush = 32'd0;
`endif
      n_cmp++; if (stall_cnt_o !== exp_stall) begin n_err++; $display("FAIL stall_cnt: got %0d exp %0d", stall_cnt_o, exp_stall); end
      n_cmp++; if (flush_cnt_o !== exp_flush) begin n_err++; $display("FAIL flush_cnt: got %0d exp %0d", flush_cnt_o, exp_flush); end
   endtask

   task automatic test_wrap();
      @(posedge clk_i); #1;
      drive(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk_i);
      show("wrap");
      n_cmp++; if (bus.pc_next_o !== 32'h0 || bus.PCWrite_o !== 1'b1) begin
         n_err++; $display("FAIL wrap: got pc=%h pcw=%b exp 00000000/1", bus.pc_next_o, bus.PCWrite_o); end
   endtask

   task automatic test_memw_redirect_wins();
      @(posedge clk_i); #1;
      drive(32'h80, 1'b1, 32'h700, 1'b0, 1'b0);
      @(negedge clk_i);
      show("pend");
      @(posedge clk_i); #1;
      drive(32'h80, 1'b1, 32'h800, 1'b0, 1'b1);
      @(negedge clk_i);
      show("pend_redir");
      n_cmp++; if (bus.pc_next_o !== 32'h800 || bus.PCWrite_o !== 1'b1) begin
         n_err++; $display("FAIL pend_redir: got pc=%h pcw=%b exp 00000800/1", bus.pc_next_o, bus.PCWrite_o); end
      @(posedge clk_i); #1;
      drive(32'h800, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk_i);
      show("pend_clear");
      n_cmp++; if (bus.pc_next_o !== 32'h804 || bus.IF_flush_o !== 1'b0) begin
         n_err++; $display("FAIL pend_clear: got pc=%h flush=%b exp 00000804/0", bus.pc_next_o, bus.IF_flush_o); end
   endtask

   task automatic test_mid_reset();
      @(posedge clk_i); #1;
      drive(32'h50, 1'b1, 32'h500, 1'b0, 1'b0);
      @(negedge clk_i);
      show("mid_enter");
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      drive(32'h50, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk_i);
      show("mid_rst");
      n_cmp++; if (bus.PCWrite_o !== 1'b0 || bus.IF_flush_o !== 1'b1 || bus.pc_next_o !== 32'h0) begin
         n_err++; $display("FAIL mid_rst: got pcw=%b flush=%b pc=%h exp 0/1/00000000", bus.PCWrite_o, bus.IF_flush_o, bus.pc_next_o); end
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      drive(32'h60, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk_i);
      show("mid_post");
      n_cmp++; if (bus.pc_next_o !== 32'h64 || bus.IF_flush_o !== 1'b0 || bus.PCWrite_o !== 1'b1) begin
         n_err++; $display("FAIL mid_post: got pc=%h flush=%b pcw=%b exp 00000064/0/1", bus.pc_next_o, bus.IF_flush_o, bus.PCWrite_o); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_load_use();
      test_redirect();
      test_memwait();
      test_wrap();
      test_memw_redirect_wins();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pc_write_ctrl.md
PC_WRITE_CTRL -- requirements
Module: pc_write_ctrl

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port rst_i  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port pc_i  input  32  current PC (ProgramCounter pc_out_o).
REQ-004 SHALL have port redirect_i  input  1  taken branch/jump resolved this cycle.
REQ-005 SHALL have port redirect_pc_i  input  32  target of redirect_i.
REQ-006 SHALL have port load_use_i  input  1  load-use hazard detected in ID.
REQ-007 SHALL have port imem_ready_i  input  1  instruction memory has valid data for pc_i this cycle.
REQ-008 SHALL have port pc_next_o  output  32  next PC (drives ProgramCounter pc_in_i).
REQ-009 SHALL have port PCWrite_o  output  1  PC update enable (drives ProgramCounter PCWrite_i).
REQ-010 SHALL have port IFID_write_o  output  1  IF/ID register load enable.
REQ-011 SHALL have port IF_flush_o  output  1  load bubble into IF/ID.
REQ-012 SHALL have port ID_bubble_o  output  1  zero ID/EX control signals.
REQ-013 SHALL have ports stall_cnt_o and flush_cnt_o  output  32 each  performance counters.

Function
REQ-014 SHALL keep a registered state in {RUN, HAZ, MEMW}; all outputs SHALL be combinational from state, pending registers and inputs (zero added latency).
REQ-015 Priority each cycle SHALL be redirect > load_use > imem wait > sequential.
REQ-016 RUN, no event: pc_next_o=pc_i+4 (mod 2^32, 0xFFFFFFFC wraps to 0x00000000), PCWrite_o=1, IFID_write_o=1, flush/bubble=0.
REQ-017 redirect_i=1 and imem_ready_i=1: pc_next_o=redirect_pc_i, PCWrite_o=1, IF_flush_o=1, IFID_write_o=1; any simultaneous load_use_i SHALL be ignored; next state RUN.
REQ-018 redirect_i=1 and imem_ready_i=0: SHALL latch redirect_pc_i into pend_pc, set pend_vld, PCWrite_o=0, IF_flush_o=1; next state MEMW.
REQ-019 RUN, load_use_i=1, no redirect: PCWrite_o=0, IFID_write_o=0, ID_bubble_o=1; next state HAZ.
REQ-020 HAZ: load_use_i SHALL be ignored; behaves as RUN otherwise (including redirect); next state RUN unless MEMW entered; guarantees exactly one stall cycle per hazard.
REQ-021 RUN or HAZ, imem_ready_i=0, no redirect: PCWrite_o=0, IFID_write_o=1, IF_flush_o=1; next state MEMW.
REQ-022 MEMW, imem_ready_i=0: PCWrite_o=0, IF_flush_o=1; a new redirect_i SHALL overwrite pend_pc (latest wins).
REQ-023 MEMW, imem_ready_i=1: if pend_vld, pc_next_o=pend_pc, IF_flush_o=1, clear pend_vld; else pc_next_o=pc_i+4, IF_flush_o=0; PCWrite_o=1; next state RUN; a redirect_i in this same cycle SHALL take precedence over pend_pc.
REQ-024 pend_vld SHALL never be set outside MEMW on the following cycle.

Reset
REQ-025 While rst_i=0: state=RUN, pend_vld=0, pend_pc=0, counters=0, PCWrite_o=0, IFID_write_o=0, IF_flush_o=1, ID_bubble_o=0, pc_next_o=0.
REQ-026 Reset asserted mid-MEMW SHALL discard pend_pc; first post-reset cycle behaves as RUN.

Configuration
REQ-027 With macro PC_WRITE_CTRL_PERF_CNT_EN defined: stall_cnt_o SHALL increment (wrapping) each cycle PCWrite_o=0 and rst_i=1; flush_cnt_o SHALL increment each cycle IF_flush_o=1 and rst_i=1.
REQ-028 Without PC_WRITE_CTRL_PERF_CNT_EN: no counter registers; stall_cnt_o and flush_cnt_o SHALL be constant 0.

Verification
REQ-029 Reset release, pc_i=0x0, imem_ready_i=1 for 3 cycles -> pc_next_o 0x4, 0x8, 0xC with PCWrite_o=1.
REQ-030 pc_i=0x20, load_use_i=1 held 2 cycles -> one cycle PCWrite_o=0, ID_bubble_o=1; second cycle pc_next_o=0x24, PCWrite_o=1.
REQ-031 pc_i=0x40, redirect_i=1, redirect_pc_i=0x100, load_use_i=1 -> pc_next_o=0x100, PCWrite_o=1, IF_flush_o=1, ID_bubble_o=0.
REQ-032 imem_ready_i=0 three cycles, redirect 0x200 in cycle 1 then 0x300 in cycle 2, ready in cycle 4 -> PCWrite_o=0 cycles 1-3, cycle 4 pc_next_o=0x300.
REQ-033 pc_i=0xFFFFFFFC sequential -> pc_next_o=0x00000000.
REQ-034 With PC_WRITE_CTRL_PERF_CNT_EN, scenario REQ-032 -> stall_cnt_o=3, flush_cnt_o=4; without macro both remain 0.
